// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-read-port register file with pending-write scoreboard
// Optional write-to-read bypass on the read ports: define REGFILE_BYPASS_EN.
module regfile_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NRD    = 2
) (
   input  logic                    clk,
   input  logic                    SYS_reset,
   input  logic [NRD*ADDR_W-1:0]   RF_rd_addr,
   output logic [NRD*DATA_W-1:0]   RF_rd_data,
   output logic [NRD-1:0]          RF_rd_busy,
   input  logic                    RF_wr_en,
   input  logic [ADDR_W-1:0]       RF_wr_addr,
   input  logic [DATA_W-1:0]       RF_wr_data,
   input  logic                    RF_res_vld,
   input  logic [ADDR_W-1:0]       RF_res_addr,
   output logic [ADDR_W:0]         RF_pend_cnt,
   input  logic [ADDR_W-1:0]       RF_dbg_addr,
   output logic [DATA_W-1:0]       RF_dbg_data
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  r_pend;
   logic [ADDR_W:0]   r_pend_cnt;

   logic w_wr_ok;
   logic w_res_ok;
   logic w_set;
   logic w_clr;

   assign w_wr_ok  = RF_wr_en   && (RF_wr_addr  != '0);
   assign w_res_ok = RF_res_vld && (RF_res_addr != '0);

   // A same-address reserve overrides the clear, so the count only sees real transitions.
   assign w_set = w_res_ok && !r_pend[RF_res_addr];
   assign w_clr = w_wr_ok && r_pend[RF_wr_addr] &&
                  !(w_res_ok && (RF_res_addr == RF_wr_addr));

   always_ff @(posedge clk) begin
      if (SYS_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_pend     <= '0;
         r_pend_cnt <= '0;
      end else begin
         if (w_wr_ok) begin
            r_mem[RF_wr_addr] <= RF_wr_data;
         end
         if (w_clr) begin
            r_pend[RF_wr_addr] <= 1'b0;
         end
         if (w_res_ok) begin
            r_pend[RF_res_addr] <= 1'b1;
         end
         r_pend_cnt <= r_pend_cnt + (ADDR_W+1)'(w_set) - (ADDR_W+1)'(w_clr);
      end
   end

   assign RF_pend_cnt = r_pend_cnt;
   assign RF_dbg_data = r_mem[RF_dbg_addr];

   // Entry 0 is never written or reserved, so it reads 0 and not-busy without a special case.
   for (genvar g = 0; g < NRD; g++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      assign w_ra = RF_rd_addr[g*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
      logic w_hit;
      logic w_res_hit;
      assign w_hit     = w_wr_ok && (RF_wr_addr == w_ra);
      assign w_res_hit = w_res_ok && (RF_res_addr == w_ra);
      assign RF_rd_data[g*DATA_W +: DATA_W] = w_hit ? RF_wr_data : r_mem[w_ra];
      assign RF_rd_busy[g] = w_hit ? (w_res_hit && r_pend[w_ra]) : r_pend[w_ra];
`else
      assign RF_rd_data[g*DATA_W +: DATA_W] = r_mem[w_ra];
      assign RF_rd_busy[g] = r_pend[w_ra];
`endif
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb (NRD=1, 2 and 4 instances)
// Expectations follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_sb;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [4*AW-1:0]   rd_addr;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [DW-1:0]     wr_data;
   logic              res_vld;
   logic [AW-1:0]     res_addr;
   logic [AW-1:0]     dbg_addr;

   logic [4*DW-1:0]   rd_data4;
   logic [2*DW-1:0]   rd_data2;
   logic [DW-1:0]     rd_data1;
   logic [3:0]        busy4;
   logic [1:0]        busy2;
   logic              busy1;
   logic [AW:0]       cnt4, cnt2, cnt1;
   logic [DW-1:0]     dbg4, dbg2, dbg1;

   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(4)) u_dut4 (
      .clk(clk), .SYS_reset(rst),
      .RF_rd_addr(rd_addr), .RF_rd_data(rd_data4), .RF_rd_busy(busy4),
      .RF_wr_en(wr_en), .RF_wr_addr(wr_addr), .RF_wr_data(wr_data),
      .RF_res_vld(res_vld), .RF_res_addr(res_addr), .RF_pend_cnt(cnt4),
      .RF_dbg_addr(dbg_addr), .RF_dbg_data(dbg4));

   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(2)) u_dut2 (
      .clk(clk), .SYS_reset(rst),
      .RF_rd_addr(rd_addr[2*AW-1:0]), .RF_rd_data(rd_data2), .RF_rd_busy(busy2),
      .RF_wr_en(wr_en), .RF_wr_addr(wr_addr), .RF_wr_data(wr_data),
      .RF_res_vld(res_vld), .RF_res_addr(res_addr), .RF_pend_cnt(cnt2),
      .RF_dbg_addr(dbg_addr), .RF_dbg_data(dbg2));

   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(1)) u_dut1 (
      .clk(clk), .SYS_reset(rst),
      .RF_rd_addr(rd_addr[AW-1:0]), .RF_rd_data(rd_data1), .RF_rd_busy(busy1),
      .RF_wr_en(wr_en), .RF_wr_addr(wr_addr), .RF_wr_data(wr_data),
      .RF_res_vld(res_vld), .RF_res_addr(res_addr), .RF_pend_cnt(cnt1),
      .RF_dbg_addr(dbg_addr), .RF_dbg_data(dbg1));

   int errors = 0;
   int checks = 0;

   // Reference model: plain array of values and a set of pending registers.
   logic [DW-1:0] m_mem  [DEPTH];
   bit            m_pend [DEPTH];

   function automatic int m_cnt();
      int n = 0;
      for (int i = 0; i < DEPTH; i++) n += m_pend[i] ? 1 : 0;
      return n;
   endfunction

   function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
      if (wr_en && wr_addr == a && a != 0) return wr_data;
`endif
      return m_mem[a];
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
      if (wr_en && wr_addr == a && a != 0) return (res_vld && res_addr == a) ? m_pend[a] : 1'b0;
`endif
      return m_pend[a];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic r, input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic rv, input logic [AW-1:0] ra);
      rst = r; wr_en = we; wr_addr = wa; wr_data = wd; res_vld = rv; res_addr = ra;
   endtask

   task automatic set_rd(input logic [AW-1:0] a);
      rd_addr  = {4{a}};
      dbg_addr = a;
   endtask

   // Advance one clock edge, updating the model from the inputs seen at that edge.
   task automatic edge_step();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
         end
      end else begin
         if (wr_en && wr_addr != 0) begin
            m_mem[wr_addr]  = wr_data;
            m_pend[wr_addr] = 1'b0;
         end
         if (res_vld && res_addr != 0) m_pend[res_addr] = 1'b1;
      end
      #1;
   endtask

   task automatic check_all();
      logic [AW-1:0] a;
      for (int p = 0; p < 4; p++) begin
         a = rd_addr[p*AW +: AW];
         chk($sformatf("n4_data%0d", p), rd_data4[p*DW +: DW], exp_data(a));
         chk($sformatf("n4_busy%0d", p), 32'(busy4[p]), 32'(exp_busy(a)));
         if (p < 2) begin
            chk($sformatf("n2_data%0d", p), rd_data2[p*DW +: DW], exp_data(a));
            chk($sformatf("n2_busy%0d", p), 32'(busy2[p]), 32'(exp_busy(a)));
         end
         if (p < 1) begin
            chk("n1_data0", rd_data1, exp_data(a));
            chk("n1_busy0", 32'(busy1), 32'(exp_busy(a)));
         end
      end
      chk("n4_cnt", 32'(cnt4), 32'(m_cnt()));
      chk("n2_cnt", 32'(cnt2), 32'(m_cnt()));
      chk("n1_cnt", 32'(cnt1), 32'(m_cnt()));
      chk("n4_dbg", dbg4, m_mem[dbg_addr]);
      chk("n2_dbg", dbg2, m_mem[dbg_addr]);
      chk("n1_dbg", dbg1, m_mem[dbg_addr]);
   endtask

   typedef struct {
      logic          we;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic          rv;
      logic [AW-1:0] ra;
      logic [AW-1:0] rd;
      logic [DW-1:0] ed;
      logic          eb;
      int            ec;
   } vec_t;

   vec_t tbl [12];

   initial begin
      // Expected values are the pre-edge (combinational) view in the cycle the row is driven.
      tbl[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 32'h0,        0, 0};
      tbl[1]  = '{0, 0, 32'h0,        0, 0, 5, 32'hDEADBEEF, 0, 0};
      tbl[2]  = '{1, 0, 32'h1234,     0, 0, 0, 32'h0,        0, 0};
      tbl[3]  = '{0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0};
      tbl[4]  = '{0, 0, 32'h0,        1, 7, 7, 32'h0,        0, 0};
      tbl[5]  = '{0, 0, 32'h0,        0, 0, 7, 32'h0,        1, 1};
      tbl[6]  = '{1, 3, 32'hA,        1, 3, 7, 32'h0,        1, 1};
      tbl[7]  = '{0, 0, 32'h0,        0, 0, 3, 32'hA,        1, 2};
      tbl[8]  = '{1, 3, 32'hB,        1, 4, 4, 32'h0,        0, 2};
      tbl[9]  = '{0, 0, 32'h0,        0, 0, 3, 32'hB,        0, 2};
      tbl[10] = '{1, 7, 32'h55,       0, 0, 4, 32'h0,        1, 2};
      tbl[11] = '{0, 0, 32'h0,        0, 0, 7, 32'h55,       0, 1};

      set_in(1, 0, 0, 0, 0, 0);
      set_rd(0);
      edge_step();
      edge_step();
      set_in(0, 0, 0, 0, 0, 0);

      for (int a = 0; a < DEPTH; a++) begin
         set_rd(AW'(a));
         @(negedge clk);
         for (int p = 0; p < 4; p++) begin
            chk($sformatf("rst_data r%0d p%0d", a, p), rd_data4[p*DW +: DW], 32'h0);
            chk($sformatf("rst_busy r%0d p%0d", a, p), 32'(busy4[p]), 32'h0);
         end
         chk($sformatf("rst_dbg r%0d", a), dbg4, 32'h0);
         chk("rst_cnt", 32'(cnt4), 32'h0);
         edge_step();
      end

      for (int i = 0; i < 12; i++) begin
         set_in(0, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].rv, tbl[i].ra);
         set_rd(tbl[i].rd);
         @(negedge clk);
         chk($sformatf("vec%0d_data", i), rd_data4[DW-1:0], tbl[i].ed);
         chk($sformatf("vec%0d_busy", i), 32'(busy4[0]), 32'(tbl[i].eb));
         chk($sformatf("vec%0d_cnt", i), 32'(cnt4), 32'(tbl[i].ec));
         chk($sformatf("vec%0d_dbg", i), dbg4, tbl[i].ed);
         edge_step();
      end

      // Write-back into a pending register: bypass-dependent same-cycle view.
      set_in(0, 0, 0, 0, 1, 9);
      set_rd(9);
      edge_step();
      set_in(0, 1, 9, 32'h55, 0, 0);
      @(negedge clk);
`ifdef REGFILE_BYPASS_EN
      chk("wb_same_data", rd_data4[DW-1:0], 32'h55);
      chk("wb_same_busy", 32'(busy4[0]), 32'h0);
`else
      chk("wb_same_data", rd_data4[DW-1:0], 32'h0);
      chk("wb_same_busy", 32'(busy4[0]), 32'h1);
`endif
      chk("wb_same_dbg", dbg4, 32'h0);
      chk("wb_same_cnt", 32'(cnt4), 32'h2);
      edge_step();
      set_in(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("wb_next_data", rd_data4[DW-1:0], 32'h55);
      chk("wb_next_busy", 32'(busy4[0]), 32'h0);
      chk("wb_next_cnt", 32'(cnt4), 32'h1);
      edge_step();

      // Write and reserve the same register in one cycle.
      set_in(0, 1, 9, 32'h66, 1, 9);
      @(negedge clk);
`ifdef REGFILE_BYPASS_EN
      chk("wr_res_data", rd_data4[DW-1:0], 32'h66);
`else
      chk("wr_res_data", rd_data4[DW-1:0], 32'h55);
`endif
      chk("wr_res_busy", 32'(busy4[0]), 32'h0);
      edge_step();
      set_in(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("wr_res_next_data", rd_data4[DW-1:0], 32'h66);
      chk("wr_res_next_busy", 32'(busy4[0]), 32'h1);
      chk("wr_res_next_cnt", 32'(cnt4), 32'h2);
      edge_step();

      for (int a = 1; a < DEPTH; a++) begin
         set_in(0, 0, 0, 0, 1, AW'(a));
         edge_step();
      end
      set_in(0, 0, 0, 0, 0, 0);
      set_rd(31);
      @(negedge clk);
      chk("all_res_cnt", 32'(cnt4), 32'd31);
      chk("all_res_busy31", 32'(busy4[3]), 32'h1);
      edge_step();

      set_in(1, 1, 2, 32'h77, 1, 6);
      edge_step();
      set_in(0, 0, 0, 0, 0, 0);
      set_rd(2);
      @(negedge clk);
      chk("rst_mid_cnt", 32'(cnt4), 32'h0);
      chk("rst_mid_data", rd_data4[DW-1:0], 32'h0);
      chk("rst_mid_busy", 32'(busy4[0]), 32'h0);
      chk("rst_mid_dbg", dbg4, 32'h0);
      edge_step();

      for (int c = 0; c < 600; c++) begin
         logic [AW-1:0] ra [6];
         for (int k = 0; k < 6; k++) begin
            ra[k] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31))
                                                : AW'($urandom_range(0, 7));
         end
         set_in(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1), ra[0],
                DW'($urandom), ($urandom_range(0, 2) == 0), ra[1]);
         rd_addr  = {ra[5], ra[4], ra[3], ra[2]};
         dbg_addr = ($urandom_range(0, 1) == 1) ? ra[0] : ra[2];
         @(negedge clk);
         check_all();
         edge_step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port register file with an integrated pending-write scoreboard, the next-generation replacement for the MIPS core's two-read/one-write register file. It serves the decode stage: it provides NRD combinational read ports with optional write-to-read bypass. Per-register pending bits let decode detect RAW hazards on in-flight producers, replacing the separate hazard-compare logic in the pipeline.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W entries
- NRD, 2, number of read ports (1..4)

Ports:
- clk  in  1  clock; all state updates on rising edge
- SYS_reset  in  1  reset, synchronous, active-high
- RF_rd_addr  in  NRD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- RF_rd_data  out  NRD*DATA_W  read data; port i at [i*DATA_W +: DATA_W]
- RF_rd_busy  out  NRD  port i source has a pending, not-yet-written producer
- RF_wr_en  in  1  write-back strobe
- RF_wr_addr  in  ADDR_W  write-back address
- RF_wr_data  in  DATA_W  write-back data
- RF_res_vld  in  1  reserve strobe (instruction issued with destination)
- RF_res_addr  in  ADDR_W  destination being reserved
- RF_pend_cnt  out  ADDR_W+1  number of entries currently pending
- RF_dbg_addr  in  ADDR_W  debug read address
- RF_dbg_data  out  DATA_W  debug read data (array contents, never bypassed)

## Operation
- Entry 0 is hardwired zero: writes and reserves to address 0 are ignored. Reads of 0 return 0 and busy 0.
- Write: on the rising edge with RF_wr_en=1 and RF_wr_addr!=0, array[RF_wr_addr] <= RF_wr_data, and pending[RF_wr_addr] is cleared.
- Reserve: on the rising edge with RF_res_vld=1 and RF_res_addr!=0, pending[RF_res_addr] is set.
- Reserve and write to the same address in the same cycle: reserve wins, the entry stays or becomes pending, and the array is still written.
- Reserving an already-pending entry leaves it pending. A write to a non-pending entry updates data only.
- RF_pend_cnt is maintained incrementally and always equals popcount(pending):
  - +1 when a bit goes 0->1
  - -1 when a bit goes 1->0
  - net change when both occur on different addresses in one cycle
- Read port i (combinational):
  - rd_data = array[rd_addr_i], subject to bypass (see Configuration)
  - rd_busy = pending[rd_addr_i], subject to bypass
- Debug port: RF_dbg_data = array[RF_dbg_addr], combinational.

## Timing
- Reset, when SYS_reset=1 at a rising edge:
  - all array entries, all pending bits and RF_pend_cnt go to 0
  - writes and reserves in that cycle are discarded
  - a mid-operation reset drops all outstanding reservations
- After reset, all RF_rd_data=0, RF_rd_busy=0 and RF_dbg_data=0 (outputs follow state combinationally).
- Read latency is 0 cycles; reads are purely combinational from addresses, state and the write port.
- Write-to-array latency is 1 edge; with bypass the written value is visible on read ports in the same cycle.
- Reserve-to-busy latency is 1 edge; reserve never bypasses, so the same-cycle read shows the prior pending state.
- No back-pressure: every strobe is accepted in the cycle it is asserted.

## Configuration
- Macro REGFILE_BYPASS_EN. When defined, for read port i with RF_wr_en=1, RF_wr_addr==rd_addr_i and rd_addr_i!=0:
  - rd_data = RF_wr_data
  - rd_busy = 0, unless RF_res_vld=1 with RF_res_addr==rd_addr_i in the same cycle, in which case busy = prior pending bit
- When not defined:
  - reads return array contents only
  - busy reflects the registered pending bit only
  - the decoder must wait one cycle after write-back
- RF_dbg_data is never bypassed in either build.

## Test plan
- Reset, then read all addresses on every port -> data 0, busy 0, RF_pend_cnt=0.
- Write 0xDEADBEEF to r5, next cycle read r5 on all ports -> 0xDEADBEEF. Write 0x1234 to r0 -> r0 still reads 0.
- Reserve r7; next cycle port0=r7 -> busy=1 and pend_cnt=1. Write r7=0x55 -> bypass build: same cycle data 0x55, busy 0. Non-bypass build: busy 1 that cycle, data 0x55 and busy 0 next cycle. pend_cnt=0 after the write edge.
- Same cycle: reserve r3 and write r3=0xA -> r3 pending, array r3=0xA, pend_cnt=1. Same cycle: reserve r4 and write r3 -> r4 pending, r3 clear, pend_cnt=1.
- Reserve r1..r31 on consecutive cycles -> pend_cnt=31. Assert SYS_reset together with a write to r2 -> all cleared, pend_cnt=0, r2 reads 0.
- Random regression: reserve/write/read traffic against a reference model -> per-cycle match of rd_data, rd_busy, pend_cnt and dbg_data on every port, with NRD=1, 2 and 4.
